consmax_lut_loader: RTL and testbench

- Writer side of the ConSmax LUT write port; it drives lut_waddr/lut_wen/lut_wdata into the consmax block.
- Accepts a stream of FP LUT entries (sign/exp/mantissa packed, LUT_DATA bits) over a valid/ready handshake.
- Writes a programmable contiguous range of the concatenated two-LUT address space, LUT0 followed by LUT1.
- Raises busy so the upstream datapath holds idata_valid low while the LUTs are being rewritten.

---
 rtl/consmax_lut_loader.sv | 114 +++++++++++
 tb/tb_consmax_lut_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/consmax_lut_loader.sv
// Streams FP LUT entries into the ConSmax LUT write port, covering a programmable
// contiguous range of the concatenated LUT0/LUT1 address space.
module consmax_lut_loader #(
  parameter int LUT_DATA  = 16,
  parameter int LUT_ADDR  = 4,
  parameter int LUT_DEPTH = 2**LUT_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LUT_ADDR:0]     cfg_base,
  input  logic [LUT_ADDR+1:0]   cfg_len,
  input  logic [LUT_DATA-1:0]   s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [LUT_ADDR:0]     lut_waddr,
  output logic                  lut_wen,
  output logic [LUT_DATA-1:0]   lut_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam int TOT = 2 * LUT_DEPTH;
  localparam logic [LUT_ADDR:0]   PTR_LAST = (LUT_ADDR+1)'(TOT - 1);
  localparam logic [LUT_ADDR+1:0] REM_ONE  = (LUT_ADDR+2)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [LUT_ADDR:0]     ptr_q, ptr_d;
  logic [LUT_ADDR+1:0]   rem_q, rem_d;
  logic [LUT_ADDR:0]     waddr_q, waddr_d;
  logic [LUT_DATA-1:0]   wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  accept;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wen_d     = 1'b0;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    s_ready   = (state_q == S_LOAD) && !abort;
    accept    = s_valid && s_ready;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          ptr_d     = cfg_base;
          rem_d     = cfg_len;
          aborted_d = 1'b0;
          state_d   = (cfg_len == '0) ? S_FLUSH : S_LOAD;
        end
      end
      S_LOAD: begin
        // Abort wins over any beat this cycle; a write already in flight still lands.
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (accept) begin
          wen_d   = 1'b1;
          waddr_d = ptr_q;
          wdata_d = s_data;
          ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_q == REM_ONE) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign lut_waddr = waddr_q;
  assign lut_wdata = wdata_q;
  assign lut_wen   = wen_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  // Upstream must see busy until the final write has actually been presented.
  assign busy      = (state_q != S_IDLE) || wen_q;

endmodule

// File: tb/tb_consmax_lut_loader.sv
// Randomized bench for consmax_lut_loader; expected writes come from the
// address rule (base + n) mod TOT applied to the accepted beats in order.
module tb_consmax_lut_loader;
  localparam int LUT_DATA = 16;
  localparam int LUT_ADDR = 4;
  localparam int TOT      = 2 * (2**LUT_ADDR);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [LUT_ADDR:0]   cfg_base = '0;
  logic [LUT_ADDR+1:0] cfg_len = '0;
  logic [LUT_DATA-1:0] s_data = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [LUT_ADDR:0]   lut_waddr;
  logic                lut_wen;
  logic [LUT_DATA-1:0] lut_wdata;
  logic                busy;
  logic                done;
  logic                aborted;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  consmax_lut_loader #(.LUT_DATA(LUT_DATA), .LUT_ADDR(LUT_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .cfg_len(cfg_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .lut_waddr(lut_waddr), .lut_wen(lut_wen), .lut_wdata(lut_wdata),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_waddr"}, 32'(lut_waddr), 0);
    check({tag, "_wen"}, 32'(lut_wen), 0);
    check({tag, "_wdata"}, 32'(lut_wdata), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_aborted"}, 32'(aborted), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ready"}, 32'(s_ready), 0);
  endtask

  // vmode 0: s_valid always high; 1: random. abort_after >= 0 aborts once that
  // many beats were accepted. ign issues a stray start while loading.
  task automatic run_load(input int base, input int len, input int vmode,
                          input int abort_after, input bit ign);
    int acc, wr, last_acc, st_cyc, done_cyc, abort_cyc;
    logic pend;
    logic [LUT_ADDR:0] exp_addr;
    logic [LUT_DATA-1:0] exp_data;
    acc = 0; wr = 0; last_acc = -1; done_cyc = -1; abort_cyc = -1;
    pend = 1'b0; exp_addr = '0; exp_data = '0;
    start = 1'b1; abort = 1'b0; s_valid = 1'b0;
    cfg_base = (LUT_ADDR+1)'(base);
    cfg_len = (LUT_ADDR+2)'(len);
    st_cyc = cyc;
    step();
    start = 1'b0;
    for (int t = 0; t < 400; t++) begin
      check("wen", 32'(lut_wen), 32'(pend));
      if (pend) begin
        check("waddr", 32'(lut_waddr), 32'(exp_addr));
        check("wdata", 32'(lut_wdata), 32'(exp_data));
        wr++;
      end
      if (abort_after >= 0) begin
        check("no_done", 32'(done), 0);
        if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
          check("busy_after_abort", 32'(busy), 0);
          check("aborted_set", 32'(aborted), 1);
        end
        if (abort_cyc >= 0 && cyc >= abort_cyc + 3) break;
      end else if (done) begin
        done_cyc = cyc;
        check("busy_at_done", 32'(busy), 0);
        break;
      end else begin
        check("busy_loading", 32'(busy), 1);
      end
      abort = (abort_after >= 0 && abort_cyc < 0 && acc == abort_after);
      if (abort) abort_cyc = cyc;
      s_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      s_data = LUT_DATA'($urandom);
      if (ign && t == 3) begin
        start = 1'b1; cfg_base = 5'd7; cfg_len = 6'd3;
      end else begin
        start = 1'b0;
      end
      #1;
      if (abort) check("ready_in_abort", 32'(s_ready), 0);
      if (len == 0) check("ready_zero_len", 32'(s_ready), 0);
      pend = s_valid && s_ready;
      if (pend) begin
        exp_addr = (LUT_ADDR+1)'((base + acc) % TOT);
        exp_data = s_data;
        acc++;
        last_acc = cyc;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    check("write_count", 32'(wr), 32'(acc));
    if (abort_after >= 0) begin
      check("acc_count_abort", 32'(acc), 32'(abort_after));
    end else begin
      check("acc_count", 32'(acc), 32'(len));
      check("done_seen", 32'(done_cyc >= 0), 1);
      if (len > 0) check("done_latency", 32'(done_cyc - last_acc), 2);
      else         check("done_latency_zero", 32'(done_cyc - st_cyc), 2);
      check("aborted_clear", 32'(aborted), 0);
      step();
      check("done_pulse_width", 32'(done), 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) step();
    check_idle_zero("reset");
    rst = 1'b1;
    step();

    run_load(0, 32, 0, -1, 1'b0);
    run_load(0, 32, 1, -1, 1'b1);
    run_load(30, 4, 0, -1, 1'b0);
    run_load(30, 40, 1, -1, 1'b0);
    run_load(0, 0, 0, -1, 1'b0);
    run_load(0, 32, 0, 10, 1'b0);

    // start together with abort in IDLE must leave everything untouched
    start = 1'b1; abort = 1'b1; cfg_base = '0; cfg_len = 6'd5;
    step();
    start = 1'b0; abort = 1'b0; s_valid = 1'b1;
    repeat (3) begin
      check("ign_ready", 32'(s_ready), 0);
      check("ign_busy", 32'(busy), 0);
      check("ign_aborted", 32'(aborted), 1);
      step();
    end
    s_valid = 1'b0;

    // reset in the middle of a load
    start = 1'b1; cfg_base = '0; cfg_len = 6'd32;
    step();
    start = 1'b0;
    check("start_clears_aborted", 32'(aborted), 0);
    s_valid = 1'b1;
    repeat (4) begin
      s_data = LUT_DATA'($urandom);
      step();
    end
    check("busy_mid_load", 32'(busy), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_idle_zero("mid_reset");
    repeat (4) begin
      step();
      check("post_rst_wen", 32'(lut_wen), 0);
      check("post_rst_done", 32'(done), 0);
    end
    s_valid = 1'b0;

    for (int i = 0; i < 3; i++)
      run_load(int'($urandom_range(0, TOT - 1)), int'($urandom_range(1, 40)), 1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
